// File: rtl/cmp_link_pkg.sv
// Shared types and constants for the serial comparator link master.
package cmp_link_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_A = 3'd1,
    ST_LOAD_B = 3'd2,
    ST_CMP    = 3'd3,
    ST_RECV   = 3'd4
  } state_t;

  localparam int DIGIT_W = 2;
  localparam int WORD_W  = 8;
  localparam int DIGITS  = 4;
  localparam logic [1:0] LAST_DIGIT = 2'(DIGITS - 1);

  // A tie between the operands resolves to B, matching the comparator.
  localparam bit TIE_SEL_B = 1'b1;

  function automatic logic [WORD_W-1:0] ref_max(input logic [WORD_W-1:0] a,
                                                input logic [WORD_W-1:0] b);
    if (TIE_SEL_B) return (a > b) ? a : b;
    else           return (a >= b) ? a : b;
  endfunction

endpackage

// File: rtl/cmp_link_shreg.sv
// Right-shifting digit register: new digits enter at the MSB end, the low digit leaves first.
module cmp_link_shreg
  import cmp_link_pkg::*;
#(
  parameter int W = WORD_W
) (
  input  logic               CLK,
  input  logic               RSTL,
  input  logic               load,
  input  logic [W-1:0]       load_val,
  input  logic               shift,
  input  logic [DIGIT_W-1:0] din,
  output logic [W-1:0]       q
);

  logic [W-1:0] sreg_q, sreg_d;

  always_comb begin
    sreg_d = sreg_q;
    if (load) begin
      sreg_d = load_val;
    end else if (shift) begin
      sreg_d = {din, sreg_q[W-1:DIGIT_W]};
    end
  end

  always_ff @(posedge CLK or negedge RSTL) begin
    if (!RSTL) begin
      sreg_q <= '0;
    end else begin
      sreg_q <= sreg_d;
    end
  end

  assign q = sreg_q;

endmodule

// File: rtl/cmp_link_master.sv
// Initiator for the 2-bit serial comparator: streams A then B, pulses compare,
// collects the 4-digit result and cross-checks it against a local max.
module cmp_link_master
  import cmp_link_pkg::*;
(
  input  logic                CLK,
  input  logic                RSTL,
  input  logic                START,
  input  logic [WORD_W-1:0]   A,
  input  logic [WORD_W-1:0]   B,
  output logic                BUSY,
  output logic                DONE,
  output logic [WORD_W-1:0]   RESULT,
  output logic                CHK_ERR,
  output logic [DIGIT_W-1:0]  TX_D,
  output logic                TX_EN,
  output logic                TX_SWITCH,
  output logic                TX_CMP_EN,
  output logic                TX_MODE,
  input  logic [DIGIT_W-1:0]  RX_D
);

  localparam int TX_W = 2 * WORD_W;

  state_t              state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [WORD_W-1:0]   a_q, a_d, b_q, b_d;
  logic [WORD_W-1:0]   result_q, result_d;
  logic                done_q, done_d;
  logic                chk_err_q, chk_err_d;

  logic                tx_load, tx_shift, rx_shift;
  logic [TX_W-1:0]     tx_q;
  logic [WORD_W-1:0]   rx_q, rx_word;
  logic                unused_bits;

  cmp_link_shreg #(.W(TX_W)) u_tx_shreg (
    .CLK      (CLK),
    .RSTL     (RSTL),
    .load     (tx_load),
    .load_val ({B, A}),
    .shift    (tx_shift),
    .din      ({DIGIT_W{1'b0}}),
    .q        (tx_q)
  );

  cmp_link_shreg #(.W(WORD_W)) u_rx_shreg (
    .CLK      (CLK),
    .RSTL     (RSTL),
    .load     (tx_load),
    .load_val ({WORD_W{1'b0}}),
    .shift    (rx_shift),
    .din      (RX_D),
    .q        (rx_q)
  );

  // The word as it will stand once the digit on RX_D is shifted in.
  assign rx_word     = {RX_D, rx_q[WORD_W-1:DIGIT_W]};
  assign unused_bits = ^{tx_q[TX_W-1:DIGIT_W], rx_q[DIGIT_W-1:0]};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    result_d  = result_q;
    chk_err_d = chk_err_q;
    done_d    = 1'b0;
    tx_load   = 1'b0;
    tx_shift  = 1'b0;
    rx_shift  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (START) begin
          tx_load = 1'b1;
          a_d     = A;
          b_d     = B;
          cnt_d   = 2'd0;
          state_d = ST_LOAD_A;
        end
      end
      ST_LOAD_A: begin
        tx_shift = 1'b1;
        cnt_d    = cnt_q + 2'd1;
        if (cnt_q == LAST_DIGIT) state_d = ST_LOAD_B;
      end
      ST_LOAD_B: begin
        tx_shift = 1'b1;
        cnt_d    = cnt_q + 2'd1;
        if (cnt_q == LAST_DIGIT) state_d = ST_CMP;
      end
      ST_CMP: begin
        cnt_d   = 2'd0;
        state_d = ST_RECV;
      end
      ST_RECV: begin
        rx_shift = 1'b1;
        cnt_d    = cnt_q + 2'd1;
        if (cnt_q == LAST_DIGIT) begin
          result_d  = rx_word;
          chk_err_d = (rx_word != ref_max(a_q, b_q));
          done_d    = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTL) begin
    if (!RSTL) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 2'd0;
      a_q       <= '0;
      b_q       <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
      chk_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      result_q  <= result_d;
      done_q    <= done_d;
      chk_err_q <= chk_err_d;
    end
  end

  assign BUSY      = (state_q != ST_IDLE);
  assign TX_MODE   = BUSY;
  assign TX_EN     = (state_q == ST_LOAD_A) || (state_q == ST_LOAD_B);
  assign TX_SWITCH = (state_q == ST_LOAD_B);
  assign TX_D      = TX_EN ? tx_q[DIGIT_W-1:0] : {DIGIT_W{1'b0}};
  assign TX_CMP_EN = (state_q == ST_CMP);
  assign DONE      = done_q;
  assign RESULT    = result_q;
  assign CHK_ERR   = chk_err_q;

endmodule
